host_sequencer: RTL and testbench

//  Host-side initiator for the CPU start/ready handshake. Accepts commands from a host port:
//   - loads instruction words into program memory;
//   - launches the CPU and waits for it to return to READY, with a cycle-count watchdog;
//   - reads back data memory bytes.

---
 rtl/host_sequencer.sv | 163 ++++++++++++++++
 tb/tb_host_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_sequencer.sv
// Host-side command sequencer: program-memory writes, CPU start/ready runs with a
// cycle watchdog, and data-memory byte reads, each answered by one held response.
module host_sequencer #(
  parameter int IW      = 16,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int CNT_W   = 16,
  parameter int MAX_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [IW-1:0]    cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             pm_we,
  output logic [AW-1:0]    pm_addr,
  output logic [IW-1:0]    pm_wdata,
  output logic [AW-1:0]    dm_addr,
  input  logic [DW-1:0]    dm_rdata,
  output logic             cpu_start,
  input  logic             cpu_ready,
  output logic             cpu_reset
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PWR  = 3'd1;
  localparam logic [2:0] S_STRT = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_ABRT = 3'd4;
  localparam logic [2:0] S_DRD  = 3'd5;
  localparam logic [2:0] S_DWT  = 3'd6;
  localparam logic [2:0] S_RSP  = 3'd7;

  localparam logic [1:0] OP_PWRITE = 2'd0;
  localparam logic [1:0] OP_RUN    = 2'd1;
  localparam logic [1:0] OP_DREAD  = 2'd2;
  localparam logic [1:0] OP_CYCLES = 2'd3;

  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(MAX_CYC);

  logic [2:0]       r_state;
  logic [AW-1:0]    r_addr;
  logic [IW-1:0]    r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;
  logic [CNT_W-1:0] r_cyc;
  logic             r_cyc_err;
  logic [CNT_W-1:0] r_rsp_data;
  logic             r_rsp_err;

  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_wdog;

  // The counter includes the current cycle, so a finish or watchdog decision
  // uses the incremented value; it saturates rather than wrapping.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_wdog    = (w_cnt_inc >= W_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_cyc      <= '0;
      r_cyc_err  <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_PWRITE: begin
                r_addr  <= cmd_addr;
                r_wdata <= cmd_data;
                r_state <= S_PWR;
              end
              OP_RUN: begin
                r_cnt   <= '0;
                r_state <= S_STRT;
              end
              OP_DREAD: begin
                r_addr  <= cmd_addr;
                r_state <= S_DRD;
              end
              OP_CYCLES: begin
                r_rsp_data <= r_cyc;
                r_rsp_err  <= r_cyc_err;
                r_state    <= S_RSP;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_PWR: begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b0;
          r_state    <= S_RSP;
        end
        S_STRT: begin
          r_cnt <= w_cnt_inc;
          if (cpu_ready) begin
            r_first <= 1'b1;
            r_state <= S_RUN;
          end else if (w_wdog) begin
            r_state <= S_ABRT;
          end
        end
        S_RUN: begin
          r_cnt   <= w_cnt_inc;
          r_first <= 1'b0;
          // The CPU is still in FETCH on the first RUN cycle, so its ready is stale.
          if (cpu_ready && !r_first) begin
            r_rsp_data <= w_cnt_inc;
            r_rsp_err  <= 1'b0;
            r_cyc      <= w_cnt_inc;
            r_cyc_err  <= 1'b0;
            r_state    <= S_RSP;
          end else if (w_wdog) begin
            r_state <= S_ABRT;
          end
        end
        S_ABRT: begin
          r_rsp_data <= W_MAX;
          r_rsp_err  <= 1'b1;
          r_cyc      <= r_cnt;
          r_cyc_err  <= 1'b1;
          r_state    <= S_RSP;
        end
        S_DRD: r_state <= S_DWT;
        S_DWT: begin
          r_rsp_data <= CNT_W'(dm_rdata);
          r_rsp_err  <= 1'b0;
          r_state    <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RSP);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign pm_we     = (r_state == S_PWR);
  assign pm_addr   = r_addr;
  assign pm_wdata  = r_wdata;
  assign dm_addr   = r_addr;
  assign cpu_start = (r_state == S_STRT) && cpu_ready;
  assign cpu_reset = (r_state == S_ABRT);

endmodule

// File: tb/tb_host_sequencer.sv
// Scoreboard bench for host_sequencer: randomized commands against a run-length
// reference model, a behavioural CPU and data memory, decoupled response monitor.
module tb_host_sequencer;
  localparam int IW      = 16;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int CNT_W   = 16;
  localparam int MAX_CYC = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_addr;
  logic [IW-1:0]    cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [CNT_W-1:0] rsp_data;
  logic             rsp_err;
  logic             pm_we;
  logic [AW-1:0]    pm_addr;
  logic [IW-1:0]    pm_wdata;
  logic [AW-1:0]    dm_addr;
  logic [DW-1:0]    dm_rdata;
  logic             cpu_start;
  logic             cpu_ready;
  logic             cpu_reset;

  host_sequencer #(.IW(IW), .AW(AW), .DW(DW), .CNT_W(CNT_W), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .dm_addr(dm_addr), .dm_rdata(dm_rdata),
    .cpu_start(cpu_start), .cpu_ready(cpu_ready), .cpu_reset(cpu_reset)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [CNT_W-1:0] data;
    logic             err;
  } rsp_t;

  rsp_t               rsp_q[$];
  logic [AW+IW-1:0]   pm_q[$];
  logic [DW-1:0]      dmem[256];

  logic [CNT_W-1:0]   last_cyc = '0;
  logic               last_err = 1'b0;
  int                 exp_starts = 0;
  int                 exp_aborts = 0;
  int                 n_start = 0;
  int                 n_abort = 0;
  logic               hold_rsp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) dm_rdata <= dmem[dm_addr];

  // CPU model: mode 0 returns ready lat cycles after start, 1 never ready, 2 never returns.
  int   cpu_mode = 0;
  int   cpu_lat  = 2;
  int   cpu_k    = 0;
  logic cpu_busy = 1'b0;
  always @(posedge clk) begin
    if (reset || cpu_reset) begin
      cpu_busy  <= 1'b0;
      cpu_ready <= (cpu_mode != 1);
    end else if (cpu_busy) begin
      if (cpu_mode == 0 && cpu_k >= cpu_lat - 1) begin
        cpu_busy  <= 1'b0;
        cpu_ready <= 1'b1;
      end else begin
        cpu_k <= cpu_k + 1;
      end
    end else if (cpu_start) begin
      cpu_busy  <= 1'b1;
      cpu_k     <= 1;
      cpu_ready <= 1'b0;
    end else begin
      cpu_ready <= (cpu_mode != 1);
    end
  end

  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready && !reset) acc_cyc <= cyc;
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(2) != 0);
    end
  end

  initial begin : monitor
    logic             hs_prev;
    logic             held_v;
    logic [CNT_W-1:0] held_d;
    logic             held_e;
    rsp_t             r;
    logic [AW+IW-1:0] e;
    hs_prev = 1'b0;
    held_v  = 1'b0;
    held_d  = '0;
    held_e  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hs_prev = 1'b0;
        held_v  = 1'b0;
        continue;
      end
      if (hs_prev) check("accept_after_rsp", cmd_ready, 1);
      hs_prev = 1'b0;
      if (pm_we || cpu_start || cpu_reset)
        check("exclusive", $countones({pm_we, cpu_start, cpu_reset}), 1);
      if (pm_we) begin
        check("pm_we_expected", pm_q.size() > 0, 1);
        if (pm_q.size() > 0) begin
          e = pm_q.pop_front();
          check("pm_write", {pm_addr, pm_wdata}, e);
        end
      end
      if (cpu_start) n_start++;
      if (cpu_reset) begin
        n_abort++;
        check("abort_cycle", cyc - acc_cyc, MAX_CYC + 1);
      end
      if (rsp_valid) begin
        check("cmd_ready_stall", cmd_ready, 0);
        if (held_v) check("rsp_hold", {rsp_data, rsp_err}, {held_d, held_e});
        if (rsp_ready) begin
          check("rsp_expected", rsp_q.size() > 0, 1);
          if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            check("rsp_data", rsp_data, r.data);
            check("rsp_err", rsp_err, r.err);
          end
          held_v  = 1'b0;
          hs_prev = 1'b1;
        end else begin
          held_v = 1'b1;
          held_d = rsp_data;
          held_e = rsp_err;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [IW-1:0] d);
    int   t;
    logic ok;
    t  = 0;
    ok = 1'b0;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      t++;
    end
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_data  = IW'($urandom);
    if (!ok) check("accept_timeout", ok, 1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (rsp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (rsp_q.size() != 0) check("drain_timeout", rsp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_pwrite(input logic [AW-1:0] a, input logic [IW-1:0] d);
    pm_q.push_back({a, d});
    rsp_q.push_back('{data: '0, err: 1'b0});
    issue(2'd0, a, d);
  endtask

  task automatic do_dread(input logic [AW-1:0] a);
    rsp_q.push_back('{data: CNT_W'(dmem[a]), err: 1'b0});
    issue(2'd2, a, IW'($urandom));
  endtask

  task automatic do_cycles();
    rsp_q.push_back('{data: last_cyc, err: last_err});
    issue(2'd3, AW'($urandom), IW'($urandom));
  endtask

  task automatic set_cpu(input int mode, input int lat);
    wait_drain();
    cpu_mode = mode;
    cpu_lat  = lat;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // A completed run reports every cycle from start through the ready cycle.
  task automatic do_run(input int mode, input int lat);
    logic done;
    set_cpu(mode, lat);
    done = (mode == 0) && (lat + 1 < MAX_CYC);
    last_cyc = done ? CNT_W'(lat + 1) : CNT_W'(MAX_CYC);
    last_err = !done;
    if (mode != 1) exp_starts++;
    if (!done) exp_aborts++;
    rsp_q.push_back('{data: last_cyc, err: last_err});
    issue(2'd1, AW'($urandom), IW'($urandom));
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {cmd_ready, rsp_valid, rsp_err, pm_we, cpu_start, cpu_reset,
                 rsp_data, pm_addr, pm_wdata, dm_addr}, {1'b1, 53'b0});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int r;
    for (int i = 0; i < 256; i++) dmem[i] = DW'($urandom);
    dmem[8'h10] = 8'h5A;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_outputs");
    @(posedge clk);
    #1;

    do_pwrite(8'h00, 16'h0000);
    do_cycles();
    do_run(0, 5);
    do_cycles();
    do_run(1, 0);
    do_run(2, 0);
    do_cycles();
    do_run(0, 18);
    do_run(0, 20);
    do_dread(8'h10);
    do_pwrite(8'hFF, 16'hFFFF);
    do_dread(8'hFF);
    do_run(0, 2);

    wait_drain();
    hold_rsp = 1'b1;
    do_dread(8'h10);
    fork
      do_cycles();
      begin
        repeat (12) @(posedge clk);
        #1;
        hold_rsp = 1'b0;
      end
    join

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3))
        0: do_pwrite(AW'($urandom), IW'($urandom));
        1: begin
          r = $urandom_range(9);
          if (r <= 5)      do_run(0, $urandom_range(12, 2));
          else if (r == 6) do_run(0, 18);
          else if (r == 7) do_run(0, $urandom_range(25, 20));
          else if (r == 8) do_run(1, 0);
          else             do_run(2, 0);
        end
        2: do_dread(AW'($urandom));
        default: do_cycles();
      endcase
    end

    set_cpu(0, 10);
    exp_starts++;
    issue(2'd1, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_cyc = '0;
    last_err = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid_run");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_rsp_after_reset", rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    do_cycles();
    wait_drain();
    repeat (4) @(posedge clk);

    check("start_count", n_start, exp_starts);
    check("abort_count", n_abort, exp_aborts);
    check("rsp_drained", rsp_q.size(), 0);
    check("pm_drained", pm_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
